flappy_game_ctrl: RTL

Parametrised game controller for the Flappy Bird VGA design. It owns the game state machine (ready/play/lost), an N-pipe scroller whose speed is set by the heart-rate code, pipe/bird collision, pause, and current/high score. It sits between the bird physics block, the RNG and the VGA/7-segment drivers, and runs entirely in the master clock domain using a `tick` enable instead of derived clocks.

---
 rtl/flappy_game_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game controller: state machine, N-pipe scroller, collision, pause and scoring.
// Define FLAPPY_SCORE_SAT_EN to make current_score saturate instead of wrapping.
//
// state | meaning
// LOST  | bird hit a pipe or the floor; waits for rst_game
// READY | pipes parked at start positions, score cleared; waits for jump
// PLAY  | pipes scroll, collision and pause are live
module flappy_game_ctrl #(
  parameter int NUM_PIPES  = 2,
  parameter int POS_W      = 10,
  parameter int SCROLL_LEN = 345,
  parameter int GAP_W      = 8,
  parameter int SCORE_W    = 4,
  parameter int ACC_W      = 18,
  parameter int SCREEN_H   = 480,
  parameter int BIRD_X_LO  = 244,
  parameter int BIRD_X_HI  = 284,
  parameter int BIRD_HALF  = 20,
  parameter int PIPE_W     = 50,
  parameter int GAP_TOP    = 75,
  parameter int GAP_BOT    = 215
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       tick,
  input  logic                       jump,
  input  logic                       rst_game,
  input  logic                       pause_btn,
  input  logic [2:0]                 hr,
  input  logic [10:0]                bird_y,
  // random gap offset; 'rand' itself is a reserved word
  input  logic [GAP_W-1:0]           rand_gap,
  output logic [1:0]                 state,
  output logic                       paused,
  output logic [NUM_PIPES*POS_W-1:0] pipe_pos,
  output logic [NUM_PIPES*GAP_W-1:0] pipe_gap,
  output logic [SCORE_W-1:0]         current_score,
  output logic [SCORE_W-1:0]         high_score
);

  typedef enum logic [1:0] {
    ST_LOST  = 2'd0,
    ST_READY = 2'd1,
    ST_PLAY  = 2'd2
  } state_e;

  localparam int CNT_W = $clog2(NUM_PIPES + 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(100);

  function automatic logic [POS_W-1:0] init_pos(input int idx);
    return POS_W'(idx * (SCROLL_LEN / NUM_PIPES));
  endfunction

  state_e             state_q, state_d;
  logic               paused_q, paused_d;
  logic               pb_prev_q, pb_prev_d;
  logic [ACC_W:0]     acc_q, acc_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic [POS_W-1:0]   pos_q [NUM_PIPES];
  logic [POS_W-1:0]   pos_d [NUM_PIPES];
  logic [GAP_W-1:0]   gap_q [NUM_PIPES];
  logic [GAP_W-1:0]   gap_d [NUM_PIPES];

  logic [1:0]         step;
  logic               hit;
  logic [11:0]        bird_top;
  logic [11:0]        pipe_x;
  logic [11:0]        gap12;
  logic [CNT_W-1:0]   n_recycle;
`ifdef FLAPPY_SCORE_SAT_EN
  logic [SCORE_W+CNT_W-1:0] score_sum;
`endif

  always_comb begin
    unique case (hr)
      3'b001:  step = 2'd1;
      3'b011:  step = 2'd2;
      3'b111:  step = 2'd1;
      3'b000:  step = 2'd3;
      default: step = 2'd0;
    endcase
  end

  // All collision math is 12-bit unsigned, wrapping included.
  always_comb begin
    hit      = 1'b0;
    pipe_x   = '0;
    gap12    = '0;
    bird_top = 12'(SCREEN_H) - 12'(bird_y);
    for (int i = 0; i < NUM_PIPES; i++) begin
      pipe_x = 12'(SCROLL_LEN) - 12'(pos_q[i]);
      gap12  = 12'(gap_q[i]);
      if ((12'(BIRD_X_HI) > pipe_x) && (12'(BIRD_X_LO) < pipe_x + 12'(PIPE_W)) &&
          ((bird_top - 12'(BIRD_HALF) < gap12 + 12'(GAP_TOP)) ||
           (bird_top + 12'(BIRD_HALF) > gap12 + 12'(GAP_BOT))))
        hit = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    paused_d  = paused_q;
    pb_prev_d = pb_prev_q;
    score_d   = score_q;
    high_d    = high_q;
    pos_d     = pos_q;
    gap_d     = gap_q;
    n_recycle = '0;
`ifdef FLAPPY_SCORE_SAT_EN
    score_sum = '0;
`endif
    acc_d     = {1'b0, acc_q[ACC_W-1:0]} + (ACC_W+1)'(step);

    // acc_q[ACC_W] is last cycle's carry-out: the scroll strobe
    if (acc_q[ACC_W] && state_q == ST_PLAY && !paused_q) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        if (pos_q[i] < POS_W'(SCROLL_LEN)) begin
          pos_d[i] = pos_q[i] + POS_W'(1);
        end else begin
          pos_d[i]  = '0;
          gap_d[i]  = rand_gap;
          n_recycle = n_recycle + CNT_W'(1);
        end
      end
`ifdef FLAPPY_SCORE_SAT_EN
      score_sum = {{CNT_W{1'b0}}, score_q} + {{SCORE_W{1'b0}}, n_recycle};
      if (score_sum > {{CNT_W{1'b0}}, {SCORE_W{1'b1}}})
        score_d = {SCORE_W{1'b1}};
      else
        score_d = score_sum[SCORE_W-1:0];
`else
      score_d = score_q + SCORE_W'(n_recycle);
`endif
    end

    if (tick) begin
      pb_prev_d = pause_btn;
      unique case (state_q)
        ST_READY: if (jump) state_d = ST_PLAY;
        ST_PLAY: begin
          if (score_q > high_q) high_d = score_q;
          if (pause_btn && !pb_prev_q) paused_d = !paused_q;
          if (!paused_q && (hit || bird_y == 11'd0)) state_d = ST_LOST;
        end
        ST_LOST:  if (rst_game) state_d = ST_READY;
        default:  state_d = ST_READY;
      endcase
    end

    if (state_d != ST_PLAY) paused_d = 1'b0;

    if (state_d == ST_READY && state_q != ST_READY) begin
      acc_d   = '0;
      score_d = '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        pos_d[i] = init_pos(i);
        gap_d[i] = GAP_INIT;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= ST_READY;
      paused_q  <= 1'b0;
      pb_prev_q <= 1'b0;
      acc_q     <= '0;
      score_q   <= '0;
      high_q    <= '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        pos_q[i] <= init_pos(i);
        gap_q[i] <= GAP_INIT;
      end
    end else begin
      state_q   <= state_d;
      paused_q  <= paused_d;
      pb_prev_q <= pb_prev_d;
      acc_q     <= acc_d;
      score_q   <= score_d;
      high_q    <= high_d;
      pos_q     <= pos_d;
      gap_q     <= gap_d;
    end
  end

  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pack
    assign pipe_pos[g*POS_W +: POS_W] = pos_q[g];
    assign pipe_gap[g*GAP_W +: GAP_W] = gap_q[g];
  end

  assign state         = state_q;
  assign paused        = paused_q;
  assign current_score = score_q;
  assign high_score    = high_q;

endmodule
